// File: rtl/drive_sequencer.sv
// ---------------------------------------------------------------------------
// drive_sequencer
//
// Purpose:
//   Turns the pattern buffer's registered driver outputs into gate drive for
//   the pad drivers. Every pwm transition aborts whatever is running, blanks
//   both gate banks for dead_time cycles, then snapshots all data inputs and
//   applies the main drive for the new phase. After tweak_delay cycles the
//   eight tweak stages are played in order, stage_len cycles each, and the
//   block parks in HOLD with the main drive still applied.
//
//   Parameter constraints: dead_time >= 2 (lets the upstream pattern
//   buffer settle before the snapshot), stage_len >= 1, and cnt_width must
//   be wide enough for max(dead_time, 255, stage_len).
//
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   pwm              in   PWM phase, 1 = high-driving phase
//   p_drive          in   P gate pattern, active-low
//   n_drive          in   N gate pattern, active-high
//   tweak_sense      in   per-bit tweak routing, 1 = P side, 0 = N side
//   tweak_delay      in   cycles from main-drive start to tweak stage 0
//   tweak_drive_0..7 in   per-stage tweak enables
//   p_gate           out  P gate output, active-low
//   n_gate           out  N gate output, active-high
//   tweak_p          out  P-side tweak enables, active-high
//   tweak_n          out  N-side tweak enables, active-high
//   stage            out  index of the current tweak stage
//   busy             out  high while in DEAD, DRIVE or TWEAK
// ---------------------------------------------------------------------------
module drive_sequencer #(
  parameter int buffer_width = 8,
  parameter int dead_time    = 2,
  parameter int stage_len    = 4,
  parameter int cnt_width    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwm,
  input  logic [buffer_width-1:0] p_drive,
  input  logic [buffer_width-1:0] n_drive,
  input  logic [buffer_width-1:0] tweak_sense,
  input  logic [buffer_width-1:0] tweak_delay,
  input  logic [buffer_width-1:0] tweak_drive_0,
  input  logic [buffer_width-1:0] tweak_drive_1,
  input  logic [buffer_width-1:0] tweak_drive_2,
  input  logic [buffer_width-1:0] tweak_drive_3,
  input  logic [buffer_width-1:0] tweak_drive_4,
  input  logic [buffer_width-1:0] tweak_drive_5,
  input  logic [buffer_width-1:0] tweak_drive_6,
  input  logic [buffer_width-1:0] tweak_drive_7,
  output logic [buffer_width-1:0] p_gate,
  output logic [buffer_width-1:0] n_gate,
  output logic [buffer_width-1:0] tweak_p,
  output logic [buffer_width-1:0] tweak_n,
  output logic [2:0]              stage,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    DRIVE = 3'd2,
    TWEAK = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Counter reload values; the counter expires when it reaches zero, so a
  // reload of N-1 gives a window of exactly N cycles.
  localparam logic [cnt_width-1:0] DEAD_RELOAD  = cnt_width'(dead_time - 1);
  localparam logic [cnt_width-1:0] STAGE_RELOAD = cnt_width'(stage_len - 1);

  localparam logic [2:0] LAST_STAGE = 3'd7;

  state_t                           state_q, state_d;
  logic                             pwm_prev_q, pwm_prev_d;
  logic                             phase_hi_q, phase_hi_d;
  logic [cnt_width-1:0]             cnt_q, cnt_d;
  logic [2:0]                       stage_q, stage_d;

  logic [buffer_width-1:0]          snap_p_q, snap_p_d;
  logic [buffer_width-1:0]          snap_n_q, snap_n_d;
  logic [buffer_width-1:0]          snap_sense_q, snap_sense_d;
  logic [7:0][buffer_width-1:0]     snap_tdrive_q, snap_tdrive_d;

  logic [buffer_width-1:0]          p_gate_q, p_gate_d;
  logic [buffer_width-1:0]          n_gate_q, n_gate_d;
  logic [buffer_width-1:0]          tweak_p_q, tweak_p_d;
  logic [buffer_width-1:0]          tweak_n_q, tweak_n_d;
  logic                             busy_q, busy_d;

  logic [7:0][buffer_width-1:0]     tdrive_in;
  logic [buffer_width-1:0]          tweak_sel;
  logic                             pwm_edge;

  assign tdrive_in = {tweak_drive_7, tweak_drive_6, tweak_drive_5, tweak_drive_4,
                      tweak_drive_3, tweak_drive_2, tweak_drive_1, tweak_drive_0};

  // Any level change versus the last sampled pwm is an edge. pwm_prev resets
  // to 0, so a high pwm at reset release starts a sequence on the first clock.
  assign pwm_edge = (pwm != pwm_prev_q);

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the registered outputs line up with the state.
  always_comb begin
    state_d       = state_q;
    pwm_prev_d    = pwm;
    phase_hi_d    = phase_hi_q;
    cnt_d         = cnt_q;
    stage_d       = stage_q;
    snap_p_d      = snap_p_q;
    snap_n_d      = snap_n_q;
    snap_sense_d  = snap_sense_q;
    snap_tdrive_d = snap_tdrive_q;
    p_gate_d      = p_gate_q;
    n_gate_d      = n_gate_q;
    tweak_p_d     = '0;
    tweak_n_d     = '0;
    busy_d        = 1'b0;
    tweak_sel     = '0;

    if (pwm_edge) begin
      // An edge aborts everything and blanks both banks immediately.
      state_d    = DEAD;
      cnt_d      = DEAD_RELOAD;
      stage_d    = 3'd0;
      phase_hi_d = pwm;
      p_gate_d   = '1;
      n_gate_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          p_gate_d = '1;
          n_gate_d = '0;
        end

        DEAD: begin
          if (cnt_q == '0) begin
            // Dead time over: capture the pattern and apply the main drive
            // for this phase only, the other bank stays off.
            snap_p_d      = p_drive;
            snap_n_d      = n_drive;
            snap_sense_d  = tweak_sense;
            snap_tdrive_d = tdrive_in;
            stage_d       = 3'd0;
            if (phase_hi_q) begin
              p_gate_d = p_drive;
              n_gate_d = '0;
            end else begin
              p_gate_d = '1;
              n_gate_d = n_drive;
            end
            if (tweak_delay == '0) begin
              state_d = TWEAK;
              cnt_d   = STAGE_RELOAD;
            end else begin
              state_d = DRIVE;
              cnt_d   = cnt_width'(tweak_delay - 1'b1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        DRIVE: begin
          if (cnt_q == '0) begin
            state_d = TWEAK;
            stage_d = 3'd0;
            cnt_d   = STAGE_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        TWEAK: begin
          if (cnt_q == '0) begin
            if (stage_q == LAST_STAGE) begin
              state_d = HOLD;
            end else begin
              stage_d = stage_q + 3'd1;
              cnt_d   = STAGE_RELOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        HOLD: begin
        end

        default: begin
          state_d  = IDLE;
          stage_d  = 3'd0;
          p_gate_d = '1;
          n_gate_d = '0;
        end
      endcase
    end

    busy_d = (state_d == DEAD) || (state_d == DRIVE) || (state_d == TWEAK);

    // Tweaks only ever go to the bank that is currently driving, so P and N
    // tweaks can never be active together.
    if (state_d == TWEAK) begin
      tweak_sel = snap_tdrive_d[stage_d];
      if (phase_hi_d) begin
        tweak_p_d = tweak_sel & snap_sense_d;
      end else begin
        tweak_n_d = tweak_sel & ~snap_sense_d;
      end
    end
  end

  // All state, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pwm_prev_q    <= 1'b0;
      phase_hi_q    <= 1'b0;
      cnt_q         <= '0;
      stage_q       <= 3'd0;
      snap_p_q      <= '0;
      snap_n_q      <= '0;
      snap_sense_q  <= '0;
      snap_tdrive_q <= '0;
      p_gate_q      <= '1;
      n_gate_q      <= '0;
      tweak_p_q     <= '0;
      tweak_n_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_prev_q    <= pwm_prev_d;
      phase_hi_q    <= phase_hi_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      snap_p_q      <= snap_p_d;
      snap_n_q      <= snap_n_d;
      snap_sense_q  <= snap_sense_d;
      snap_tdrive_q <= snap_tdrive_d;
      p_gate_q      <= p_gate_d;
      n_gate_q      <= n_gate_d;
      tweak_p_q     <= tweak_p_d;
      tweak_n_q     <= tweak_n_d;
      busy_q        <= busy_d;
    end
  end

  assign p_gate  = p_gate_q;
  assign n_gate  = n_gate_q;
  assign tweak_p = tweak_p_q;
  assign tweak_n = tweak_n_q;
  assign stage   = stage_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// ---------------------------------------------------------------------------
// tb_drive_sequencer
//
// Purpose:
//   Directed self-checking bench for drive_sequencer with default parameters
//   (buffer_width 8, dead_time 2, stage_len 4). Expected values come from the
//   documented cycle map: off for 2 cycles after an edge, main drive from
//   E+2, stage k over [E+2+D+4k, +4), HOLD from E+2+D+32.
// ---------------------------------------------------------------------------
module tb_drive_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pwm;
  logic [7:0] p_drive;
  logic [7:0] n_drive;
  logic [7:0] tweak_sense;
  logic [7:0] tweak_delay;
  logic [7:0][7:0] td_r;
  logic [7:0] p_gate;
  logic [7:0] n_gate;
  logic [7:0] tweak_p;
  logic [7:0] tweak_n;
  logic [2:0] stage;
  logic       busy;

  int errors;
  int checks;

  drive_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm           (pwm),
    .p_drive       (p_drive),
    .n_drive       (n_drive),
    .tweak_sense   (tweak_sense),
    .tweak_delay   (tweak_delay),
    .tweak_drive_0 (td_r[0]),
    .tweak_drive_1 (td_r[1]),
    .tweak_drive_2 (td_r[2]),
    .tweak_drive_3 (td_r[3]),
    .tweak_drive_4 (td_r[4]),
    .tweak_drive_5 (td_r[5]),
    .tweak_drive_6 (td_r[6]),
    .tweak_drive_7 (td_r[7]),
    .p_gate        (p_gate),
    .n_gate        (n_gate),
    .tweak_p       (tweak_p),
    .tweak_n       (tweak_n),
    .stage         (stage),
    .busy          (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge so registered outputs are
  // stable and inputs change well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every data input and the pwm level in one go.
  task automatic applyStimulus(input logic pwm_v, input logic [7:0] pd,
                               input logic [7:0] nd, input logic [7:0] sense,
                               input logic [7:0] delay, input logic [7:0][7:0] td);
    pwm         = pwm_v;
    p_drive     = pd;
    n_drive     = nd;
    tweak_sense = sense;
    tweak_delay = delay;
    td_r        = td;
  endtask

  // Compare the complete output vector against expectations.
  task automatic checkOutput(input string tag, input logic [7:0] ep,
                             input logic [7:0] en, input logic [7:0] etp,
                             input logic [7:0] etn, input logic [2:0] es,
                             input logic eb);
    checks++;
    assert ({p_gate, n_gate, tweak_p, tweak_n, stage, busy} ===
            {ep, en, etp, etn, es, eb})
    else begin
      errors++;
      $error("[TB] FAIL %s: observed p=%h n=%h tp=%h tn=%h stage=%0d busy=%b, expected p=%h n=%h tp=%h tn=%h stage=%0d busy=%b",
             tag, p_gate, n_gate, tweak_p, tweak_n, stage, busy,
             ep, en, etp, etn, es, eb);
    end
  endtask

  // Compare a single scalar quantity against its expectation.
  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0][7:0] td;
    logic            pwm_v;
    int              d;
    int              h;

    errors = 0;
    checks = 0;
    td     = '0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, td);

    // Reset state.
    #12;
    checkOutput("reset", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);

    // High phase with delay 3; td[k] is a walking one, sense keeps the low
    // nibble so stages 4..7 are all-zero but still last 4 cycles.
    $display("[TB] high phase, delay 3");
    for (int k = 0; k < 8; k++) td[k] = 8'(1 << k);
    applyStimulus(1'b1, 8'hF0, 8'h3C, 8'h0F, 8'd3, td);
    tick();
    checkOutput("t1_dead0", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t1_dead1", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t1_drive2", 8'hF0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    p_drive = 8'h00;
    tick();
    checkOutput("t1_drive3", 8'hF0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t1_drive4", 8'hF0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checkOutput("t1_stage", 8'hF0, 8'h00, 8'(1 << k) & 8'h0F, 8'h00, 3'(k), 1'b1);
      end
    end
    tick();
    checkOutput("t1_hold", 8'hF0, 8'h00, 8'h00, 8'h00, 3'd7, 1'b0);
    tick();
    checkOutput("t1_hold2", 8'hF0, 8'h00, 8'h00, 8'h00, 3'd7, 1'b0);

    // Low phase, delay 0: stage 0 starts together with the main drive.
    $display("[TB] low phase, delay 0");
    td    = '0;
    td[3] = 8'hFF;
    applyStimulus(1'b0, 8'h00, 8'h0F, 8'hAA, 8'd0, td);
    tick();
    checkOutput("t2_dead0", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t2_dead1", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checkOutput("t2_stage", 8'hFF, 8'h0F, 8'h00, (k == 3) ? 8'h55 : 8'h00, 3'(k), 1'b1);
      end
    end
    tick();
    checkOutput("t2_hold", 8'hFF, 8'h0F, 8'h00, 8'h00, 3'd7, 1'b0);

    // Abort during stage 2 with a fresh edge.
    $display("[TB] abort during stage 2");
    for (int k = 0; k < 8; k++) td[k] = 8'(8'h11 * (k + 1));
    applyStimulus(1'b1, 8'h3C, 8'hA5, 8'h0F, 8'd0, td);
    tick();
    checkOutput("t3_dead0", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t3_dead1", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < ((k == 2) ? 2 : 4); c++) begin
        tick();
        checkOutput("t3_stage", 8'h3C, 8'h00, 8'(k + 1), 8'h00, 3'(k), 1'b1);
      end
    end
    applyStimulus(1'b0, 8'h3C, 8'hA5, 8'h0F, 8'd0, td);
    tick();
    checkOutput("t3_abort", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t3_redead1", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t3_restart", 8'hFF, 8'hA5, 8'h00, 8'h10, 3'd0, 1'b1);

    // Asynchronous reset in TWEAK, then pwm high at release.
    $display("[TB] async reset");
    rst_n = 1'b0;
    #2;
    checkOutput("t5_async_reset", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h81, 8'h00, 8'h0F, 8'd1, td);
    tick();
    checkOutput("t5_in_reset", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("t5_first_clock", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t5_dead1", 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t5_drive", 8'h81, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    checkOutput("t5_stage0", 8'h81, 8'h00, 8'h01, 8'h00, 3'd0, 1'b1);

    // Random edges: safety invariant every cycle and stage/busy timing
    // from the cycle map.
    $display("[TB] random edges");
    pwm_v = 1'b1;
    for (int e = 0; e < 1000; e++) begin
      pwm_v = ~pwm_v;
      d = $urandom_range(0, 15);
      h = $urandom_range(1, 60);
      for (int k = 0; k < 8; k++) td[k] = 8'($urandom);
      applyStimulus(pwm_v, 8'($urandom), 8'($urandom), 8'($urandom), 8'(d), td);
      for (int t = 0; t < h; t++) begin
        tick();
        checkValue("t6_safety_gate", 32'(~p_gate & n_gate), 32'd0);
        checkValue("t6_safety_tweak", 32'((tweak_p != 8'h00) && (tweak_n != 8'h00)), 32'd0);
        if (t < 2 + d) begin
          checkValue("t6_stage_busy", 32'({stage, busy}), 32'({3'd0, 1'b1}));
        end else if (t < 2 + d + 32) begin
          checkValue("t6_stage_busy", 32'({stage, busy}), 32'({3'((t - 2 - d) / 4), 1'b1}));
        end else begin
          checkValue("t6_stage_busy", 32'({stage, busy}), 32'({3'd7, 1'b0}));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
